slp_seq_infer: RTL and testbench
================================

# slp_seq_infer

Sequential, parametrised successor to the combinational single-layer perceptron inference block. It evaluates NEURON output neurons over one IN-element input vector, time-multiplexing LANE multipliers across inputs and neurons, and exposes valid/ready handshakes on input and output. It sits between the feature buffer and the next layer, wherever a fully parallel multiply-accumulate tree is too large.

## Interface
- IN, 8: number of inputs per neuron; WEIGHT = IN+1, where the last weight is the bias.
- NEURON, 4: number of output neurons.
- LANE, 2: multipliers per cycle; 1 ≤ LANE ≤ WEIGHT.
- I_CONF, W_CONF, O_CONF, `DEF_DCONF`: data configs. Only signed INT/FXP are supported, and all three share one dtype.
- ACT, `DEF_ACT`: activation; supported values are identity, ReLU, and step (step gives 1 if acc > 0, else 0).
- Derived: BEATS = ceil(WEIGHT/LANE); P_FRAC = I_FRAC+W_FRAC; ACC_W = I_PREC+W_PREC+$clog2(WEIGHT)+1.

Ports:
- clk  in  1  clock; the only clock.
- reset_  in  1  asynchronous, active-low reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block can accept.
- in  in  [IN-1:0][I_PREC-1:0]  input vector; latched on accept.
- weight  in  [NEURON-1:0][WEIGHT-1:0][W_PREC-1:0]  weights; must stay stable from the accept edge until out_valid rises. The block does not latch them.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out  out  [NEURON-1:0][O_PREC-1:0]  activated, converted results.
- ovf  out  1  one or more neurons saturated at output conversion; valid with out.
- rounded  out  1  one or more neurons discarded nonzero fraction bits; valid with out.

## Operation
- The FSM has three states: IDLE, RUN, and DONE. Reset enters IDLE and clears out, ovf, rounded, out_valid, and all counters.
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- Accept occurs when in_valid & in_ready. On accept the block:
  - latches in,
  - clears the accumulator, neuron counter n, beat counter b, ovf and rounded,
  - moves to RUN.
- RUN beat (n,b):
  - Each lane l multiplies element k = b·LANE+l by weight[n][k].
  - For k = WEIGHT-1, the input is const1 (1 for INT, 1<<I_FRAC for FXP).
  - For k ≥ WEIGHT, the lane contributes 0.
  - Products are full width (I_PREC+W_PREC, signed). They are summed and sign-extended into the ACC_W accumulator, which cannot overflow.
- On the last beat (b = BEATS-1), the block takes the final sum, applies ACT, converts to O_CONF, writes out[n], ORs the flags into ovf/rounded, resets the accumulator, and increments n (b wraps to 0).
- Conversion:
  - Arithmetic-shift right by P_FRAC-O_FRAC (floor). If O_FRAC exceeds P_FRAC, shift left instead.
  - rounded = any shifted-out bit nonzero.
  - Saturate to signed O_PREC range; ovf = saturation occurred.
  - Step activation yields 1 (INT) or 1<<O_FRAC (FXP).
- After the last beat of neuron NEURON-1, the block enters DONE with out_valid=1.
- DONE:
  - out, ovf and rounded hold until out_ready.
  - If out_ready & !in_valid, go to IDLE.
  - If out_ready & in_valid, this is a back-to-back accept: go directly to RUN.
- Neurons not yet computed keep their previous out values. out is only meaningful while out_valid is high.

## Timing
- Latency is NEURON·BEATS+1 cycles from the accept edge to out_valid high.
- Throughput is one vector per NEURON·BEATS+1 cycles with out_ready held high. There are no bubbles on back-to-back input.
- in_ready is low for the whole of RUN. in_valid during RUN is ignored, and upstream must hold it.
- Reset is asynchronous at any time, including mid-RUN or in DONE. All outputs drop to 0 immediately: out_valid=0, in_ready=0 while reset_ is low, in_ready=1 in the first cycle after release. Partial results are discarded.
- Simultaneous out_ready and in_valid in DONE completes both handshakes on the same edge.

## Test plan
- Basic (INT8, IN=4, NEURON=2, LANE=2, ReLU):
  - Stimulus: in={1,2,3,4}; w0={1,1,1,1,bias 0}; w1={-1,-1,-1,-1,bias 2}.
  - Required: out={10,0}, ovf=0, rounded=0. out_valid rises exactly 7 cycles after accept.
- Saturation (same config):
  - Stimulus: all inputs 127, all weights 127.
  - Required: acc=64643, out[0]=127, ovf=1. Neuron 1 with weights -128 gives out=0 (ReLU) without ovf.
- Rounding (FXP8, frac 4 on I/W/O, identity):
  - Stimulus: in[0]=0x18, w0[0]=0x11, all others 0.
  - Required: product 408, out[0]=25, rounded=1.
- Backpressure: out_ready low for 5 cycles in DONE.
  - Required: out_valid, out, ovf and rounded stay stable; in_ready=0. After out_ready, the same-edge accept of the next vector succeeds and the next out_valid comes 7 cycles later.
- Reset mid-RUN: assert reset_=0 at beat 3.
  - Required: out=0, out_valid=0 immediately. After release, in_ready=1. A fresh vector then produces correct results with no residue from the aborted run.
- Parameter sweep: LANE ∈ {1,3,WEIGHT} with random vectors.
  - Required: results match the reference model; latency equals NEURON·ceil(WEIGHT/LANE)+1.

Source files
------------

// File: rtl/slp_seq_infer.sv
// Sequential single-layer perceptron: LANE signed MACs per cycle, NEURON x ceil((IN+1)/LANE) beats per vector.
// Result valid NEURON*BEATS+1 cycles after accept and held in DONE until out_ready; in_ready low while computing.
module slp_seq_infer #(
   parameter int IN     = 8,
   parameter int NEURON = 4,
   parameter int LANE   = 2,
   parameter int I_PREC = 8,
   parameter int I_FRAC = 0,
   parameter int W_PREC = 8,
   parameter int W_FRAC = 0,
   parameter int O_PREC = 8,
   parameter int O_FRAC = 0,
   parameter int ACT    = 1   // 0 identity, 1 ReLU, 2 step
) (
   input  logic                                clk,
   input  logic                                reset_,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [IN-1:0][I_PREC-1:0]           in,
   input  logic [NEURON-1:0][IN:0][W_PREC-1:0] weight,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [NEURON-1:0][O_PREC-1:0]       out,
   output logic                                ovf,
   output logic                                rounded
);

   localparam int ACT_RELU = 1;
   localparam int ACT_STEP = 2;
   localparam int WEIGHT   = IN + 1;
   localparam int BEATS    = (WEIGHT + LANE - 1) / LANE;
   localparam int P_FRAC   = I_FRAC + W_FRAC;
   localparam int PW       = I_PREC + W_PREC;
   localparam int ACC_W    = PW + $clog2(WEIGHT) + 1;
   localparam int NW       = $clog2(NEURON + 1);
   localparam int BW       = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int SH       = P_FRAC - O_FRAC;
   localparam int LSH      = (SH < 0) ? -SH : 0;
   localparam int RSH      = (SH > 0) ? SH : 0;
   localparam int CW       = ACC_W + LSH;

   localparam logic [I_PREC-1:0]       CONST1 = I_PREC'(1) << I_FRAC;
   localparam logic [O_PREC-1:0]       STEP1  = O_PREC'(1) << O_FRAC;
   localparam logic [CW-1:0]           MASK   = (CW'(1) << RSH) - CW'(1);
   localparam logic signed [CW-1:0]    OMAX   = CW'((1 <<< (O_PREC - 1)) - 1);
   localparam logic signed [CW-1:0]    OMIN   = ~OMAX;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t                          state, state_nxt;
   logic                            accept;
   logic [IN-1:0][I_PREC-1:0]       in_q;
   logic [WEIGHT-1:0][I_PREC-1:0]   x_vec;
   logic [WEIGHT-1:0][W_PREC-1:0]   w_row;
   logic signed [ACC_W-1:0]         acc, acc_sum, beat_sum;
   logic signed [I_PREC-1:0]        xk;
   logic signed [W_PREC-1:0]        wk;
   logic signed [PW-1:0]            prod;
   logic [NW-1:0]                   n_cnt, fin_n;
   logic [BW-1:0]                   b_cnt;
   logic                            fin_vld;
   logic signed [ACC_W-1:0]         fin_acc, act_v;
   logic signed [CW-1:0]            ext, cv, shifted, sat_v;
   logic [O_PREC-1:0]               c_val;
   logic                            c_ovf, c_rnd;
   logic                            unused_bits;

   assign in_ready  = reset_ & ((state == S_IDLE) | ((state == S_DONE) & out_ready));
   assign out_valid = (state == S_DONE);
   assign accept    = in_valid & in_ready;

   // Bias is the top element, multiplied by the constant one.
   assign x_vec   = {CONST1, in_q};
   assign acc_sum = acc + beat_sum;

   always_comb begin
      w_row = '0;
      for (int nn = 0; nn < NEURON; nn++)
         if (n_cnt == NW'(nn)) w_row = weight[nn];
   end

   always_comb begin
      beat_sum = '0;
      xk       = '0;
      wk       = '0;
      prod     = '0;
      for (int l = 0; l < LANE; l++) begin
         xk = '0;
         wk = '0;
         for (int j = 0; j < WEIGHT; j++)
            if (int'(b_cnt) * LANE + l == j) begin
               xk = x_vec[j];
               wk = w_row[j];
            end
         prod     = PW'(xk) * PW'(wk);
         beat_sum = beat_sum + ACC_W'(prod);
      end
   end

   // Conversion runs one cycle behind the MAC, overlapping the next neuron's first beat.
   always_comb begin
      act_v = fin_acc;
      if (ACT == ACT_RELU && fin_acc < 0) act_v = '0;
      ext     = CW'(act_v);
      cv      = ext <<< LSH;
      shifted = cv >>> RSH;
      c_rnd   = |(cv & MASK);
      c_ovf   = 1'b0;
      sat_v   = shifted;
      if (shifted > OMAX) begin
         sat_v = OMAX;
         c_ovf = 1'b1;
      end else if (shifted < OMIN) begin
         sat_v = OMIN;
         c_ovf = 1'b1;
      end
      c_val = sat_v[O_PREC-1:0];
      if (ACT == ACT_STEP) begin
         c_val = (fin_acc > 0) ? STEP1 : '0;
         c_rnd = 1'b0;
         c_ovf = 1'b0;
      end
   end

   assign unused_bits = ^sat_v[CW-1:O_PREC];

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept) state_nxt = S_RUN;
         S_RUN:   if (fin_vld && fin_n == NW'(NEURON - 1)) state_nxt = S_DONE;
         S_DONE:  if (out_ready) state_nxt = in_valid ? S_RUN : S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state   <= S_IDLE;
         in_q    <= '0;
         acc     <= '0;
         n_cnt   <= '0;
         b_cnt   <= '0;
         fin_vld <= 1'b0;
         fin_acc <= '0;
         fin_n   <= '0;
         out     <= '0;
         ovf     <= 1'b0;
         rounded <= 1'b0;
      end else begin
         state   <= state_nxt;
         fin_vld <= 1'b0;
         if (accept) begin
            in_q    <= in;
            acc     <= '0;
            n_cnt   <= '0;
            b_cnt   <= '0;
            ovf     <= 1'b0;
            rounded <= 1'b0;
         end else if (state == S_RUN) begin
            // n_cnt parks at NEURON while the final conversion drains.
            if (n_cnt < NW'(NEURON)) begin
               if (b_cnt == BW'(BEATS - 1)) begin
                  fin_acc <= acc_sum;
                  fin_n   <= n_cnt;
                  fin_vld <= 1'b1;
                  acc     <= '0;
                  b_cnt   <= '0;
                  n_cnt   <= n_cnt + 1'b1;
               end else begin
                  acc   <= acc_sum;
                  b_cnt <= b_cnt + 1'b1;
               end
            end
            if (fin_vld) begin
               for (int nn = 0; nn < NEURON; nn++)
                  if (fin_n == NW'(nn)) out[nn] <= c_val;
               ovf     <= ovf | c_ovf;
               rounded <= rounded | c_rnd;
            end
         end
      end
   end

endmodule

// File: tb/tb_slp_seq_infer.sv
// Directed bench for slp_seq_infer: INT8 ReLU, FXP rounding, backpressure, reset mid-run, LANE sweep.
module tb_slp_seq_infer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_;
   int   n_tests = 0;
   int   n_fail  = 0;

   // INT8 ReLU, LANE=2
   logic             in_valid, in_ready, out_valid, out_ready, ovf, rounded;
   logic [3:0][7:0]  in_v;
   logic [1:0][4:0][7:0] w_v;
   logic [1:0][7:0]  out_v;

   // FXP Q4 identity, LANE=2
   logic             f_in_valid, f_in_ready, f_out_valid, f_out_ready, f_ovf, f_rounded;
   logic [3:0][7:0]  f_in;
   logic [1:0][4:0][7:0] f_w;
   logic [1:0][7:0]  f_out;

   // LANE sweep {1,3,5}, INT8 ReLU
   logic             s_in_valid, s_out_ready;
   logic [3:0][7:0]  s_in;
   logic [1:0][4:0][7:0] s_w;
   logic [2:0]       s_in_ready, s_out_valid, s_ovf, s_rounded;
   logic [1:0][7:0]  s_out [3];

   slp_seq_infer #(.IN(4), .NEURON(2), .LANE(2), .ACT(1)) u_int (
      .clk(clk), .reset_(reset_), .in_valid(in_valid), .in_ready(in_ready), .in(in_v),
      .weight(w_v), .out_valid(out_valid), .out_ready(out_ready), .out(out_v),
      .ovf(ovf), .rounded(rounded));

   slp_seq_infer #(.IN(4), .NEURON(2), .LANE(2), .I_FRAC(4), .W_FRAC(4), .O_FRAC(4), .ACT(0)) u_fxp (
      .clk(clk), .reset_(reset_), .in_valid(f_in_valid), .in_ready(f_in_ready), .in(f_in),
      .weight(f_w), .out_valid(f_out_valid), .out_ready(f_out_ready), .out(f_out),
      .ovf(f_ovf), .rounded(f_rounded));

   for (genvar g = 0; g < 3; g++) begin : g_sw
      localparam int LN = (g == 0) ? 1 : ((g == 1) ? 3 : 5);
      slp_seq_infer #(.IN(4), .NEURON(2), .LANE(LN), .ACT(1)) u_sw (
         .clk(clk), .reset_(reset_), .in_valid(s_in_valid), .in_ready(s_in_ready[g]), .in(s_in),
         .weight(s_w), .out_valid(s_out_valid[g]), .out_ready(s_out_ready), .out(s_out[g]),
         .ovf(s_ovf[g]), .rounded(s_rounded[g]));
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Counts rising edges after the accept edge until out_valid is seen; -1 if never.
   task automatic wait_vld(input int sel, output int lat);
      lat = -1;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk);
         @(negedge clk);
         if ((sel == 0 && out_valid) || (sel == 1 && f_out_valid)) begin
            lat = c;
            break;
         end
      end
   endtask

   int lat;
   int sw_lat [3];
   logic [1:0][7:0] sw_snap [3];
   logic [2:0] sw_snap_ovf;
   logic [1:0][7:0] exp_out;
   logic exp_ovf;
   int acc;
   int exp_lat [3] = '{11, 5, 3};

   initial begin
      reset_ = 1'b1;
      in_valid = 0; out_ready = 0; in_v = '0; w_v = '0;
      f_in_valid = 0; f_out_ready = 0; f_in = '0; f_w = '0;
      s_in_valid = 0; s_out_ready = 0; s_in = '0; s_w = '0;
      #1 reset_ = 1'b0;
      repeat (2) @(negedge clk);

      // Reset state
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_out", out_v, 0);
      check("rst_ovf", ovf, 0);
      check("rst_rounded", rounded, 0);
      reset_ = 1'b1;
      #1 check("rel_in_ready", in_ready, 1);

      // Basic: out = {10, 0}
      in_v   = {8'd4, 8'd3, 8'd2, 8'd1};
      w_v[0] = {8'd0, 8'd1, 8'd1, 8'd1, 8'd1};
      w_v[1] = {8'd2, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      in_valid = 1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 0;
      #1 check("run_in_ready", in_ready, 0);
      wait_vld(0, lat);
      check("basic_latency", lat, 7);
      check("basic_out", out_v, 16'h000A);
      check("basic_ovf", ovf, 0);
      check("basic_rounded", rounded, 0);

      // Backpressure: held for 5 cycles
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("bp_out_valid", out_valid, 1);
         check("bp_out", out_v, 16'h000A);
         check("bp_flags", {ovf, rounded}, 2'b00);
         check("bp_in_ready", in_ready, 0);
      end

      // Same-edge release + accept of the saturation vector
      in_v   = {4{8'd127}};
      w_v[0] = {5{8'd127}};
      w_v[1] = {5{8'h80}};
      in_valid = 1;
      out_ready = 1;
      #1 check("done_in_ready", in_ready, 1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 0;
      out_ready = 0;
      check("b2b_left_done", out_valid, 0);
      wait_vld(0, lat);
      check("sat_latency", lat, 7);
      check("sat_out", out_v, 16'h007F);
      check("sat_ovf", ovf, 1);
      check("sat_rounded", rounded, 0);

      // Reset mid-RUN, then a fresh vector: out = {5, 11}
      in_v   = {8'd5, 8'd0, 8'd3, 8'hFF};
      w_v[0] = {8'hFD, 8'd2, 8'd2, 8'd2, 8'd2};
      w_v[1] = {8'd0, 8'd1, 8'd0, 8'd0, 8'd0};
      in_valid = 1;
      out_ready = 1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 0;
      out_ready = 0;
      repeat (3) @(posedge clk);
      #2 reset_ = 1'b0;
      #1;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_out", out_v, 0);
      check("mid_rst_in_ready", in_ready, 0);
      check("mid_rst_ovf", ovf, 0);
      @(negedge clk);
      reset_ = 1'b1;
      #1 check("mid_rel_in_ready", in_ready, 1);
      in_valid = 1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 0;
      wait_vld(0, lat);
      check("fresh_latency", lat, 7);
      check("fresh_out", out_v, 16'h050B);
      check("fresh_flags", {ovf, rounded}, 2'b00);

      // FXP Q4 rounding: 0x18*0x11=408 -> 25 with discarded fraction
      f_in   = {8'd0, 8'd0, 8'd0, 8'h18};
      f_w[0] = {8'd0, 8'd0, 8'd0, 8'd0, 8'h11};
      f_w[1] = {8'h10, 8'd0, 8'd0, 8'd0, 8'h10};
      @(negedge clk);
      f_in_valid = 1;
      @(posedge clk);
      @(negedge clk);
      f_in_valid = 0;
      wait_vld(1, lat);
      check("fxp_latency", lat, 7);
      check("fxp_out", f_out, 16'h2819);
      check("fxp_rounded", f_rounded, 1);
      check("fxp_ovf", f_ovf, 0);

      // LANE sweep with random vectors against a reference sum
      for (int v = 0; v < 3; v++) begin
         for (int i = 0; i < 4; i++) s_in[i] = 8'(int'($urandom_range(40)) - 20);
         for (int n = 0; n < 2; n++)
            for (int i = 0; i < 5; i++) s_w[n][i] = 8'(int'($urandom_range(40)) - 20);
         exp_ovf = 1'b0;
         for (int n = 0; n < 2; n++) begin
            acc = int'($signed(s_w[n][4]));
            for (int i = 0; i < 4; i++)
               acc += int'($signed(s_in[i])) * int'($signed(s_w[n][i]));
            if (acc < 0) acc = 0;
            if (acc > 127) begin
               acc = 127;
               exp_ovf = 1'b1;
            end
            exp_out[n] = 8'(acc);
         end
         @(negedge clk);
         s_in_valid = 1;
         s_out_ready = 1;
         @(posedge clk);
         @(negedge clk);
         s_in_valid = 0;
         s_out_ready = 0;
         sw_lat = '{-1, -1, -1};
         for (int c = 1; c <= 15; c++) begin
            @(posedge clk);
            @(negedge clk);
            for (int g = 0; g < 3; g++)
               if (s_out_valid[g] && sw_lat[g] < 0) begin
                  sw_lat[g]      = c;
                  sw_snap[g]     = s_out[g];
                  sw_snap_ovf[g] = s_ovf[g];
               end
         end
         for (int g = 0; g < 3; g++) begin
            check($sformatf("sweep%0d_lane%0d_latency", v, g), sw_lat[g], exp_lat[g]);
            check($sformatf("sweep%0d_lane%0d_out", v, g), sw_snap[g], exp_out);
            check($sformatf("sweep%0d_lane%0d_ovf", v, g), sw_snap_ovf[g], exp_ovf);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
